// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: parametrised pipeline-stage register with a valid/ready
// handshake and a 2-entry skid buffer (main = head, skid = overflow).
// in_ready_o is decoded from the state register only, so downstream
// back-pressure never forms a combinational path to the upstream stage.
// stall_i freezes the stage; flush_i empties it and leaves a zero bubble.
// Saturating counters record stall cycles and flush cycles.
module pipe_skid_stage #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              clr_cnt_i,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [DATA_W-1:0]  main_q;
    logic [DATA_W-1:0]  skid_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   flush_cnt_q;
    logic               in_fire;
    logic               out_fire;

    // A transfer needs both handshake sides and neither hold nor kill.
    assign in_fire  = in_valid_i & in_ready_o & ~stall_i & ~flush_i;
    assign out_fire = out_valid_o & out_ready_i & ~stall_i & ~flush_i;

    // Outputs are pure decodes of registers; no input reaches them.
    assign out_data_o  = main_q;
    assign out_valid_o = (state != EMPTY);
    assign in_ready_o  = (state != FULL2);
    assign occ_o       = state;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // Skid-buffer FSM: flush beats stall beats handshake.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: payload flops are reset too; a zero head is the bubble
            // that downstream decodes as a NOP while out_valid_o is low.
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            // During stall both fires are low, so every branch holds.
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= FULL1;
                        main_q <= in_data_i;
                    end
                end
                FULL1: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data_i;
                    end else if (in_fire) begin
                        state  <= FULL2;
                        skid_q <= in_data_i;
                    end else if (out_fire) begin
                        state  <= EMPTY;
                        main_q <= '0;
                    end
                end
                FULL2: begin
                    // in_ready_o is low here, so only the head can leave.
                    if (out_fire) begin
                        state  <= FULL1;
                        main_q <= skid_q;
                        skid_q <= '0;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_q <= '0;
                    skid_q <= '0;
                end
            endcase
        end
    end

    // Saturating event counters; a clear wins over the same-cycle event.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_i && !flush_i && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_i && flush_cnt_q != CNT_MAX)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline-stage register, successor to the fixed IF/ID latch. Payload width is generic, e.g. {pc, inst} = 64 bits.
- Adds a valid/ready handshake with a 2-entry skid buffer, so `in_ready_o` is registered and hazard back-pressure never forms a combinational path upstream.
- Keeps the hazard-hold (`stall_i`) and `flush_i` controls.
- Adds saturating stall and flush performance counters.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...).

Parameters:
- DATA_W, 64, payload width in bits (>= 1).
- CNT_W, 16, width of each performance counter (>= 2).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- in_valid_i  input  1  upstream offers `in_data_i`.
- in_data_i  input  DATA_W  upstream payload.
- in_ready_o  output  1  stage can accept (registered).
- out_valid_o  output  1  `out_data_o` holds a live entry.
- out_data_o  output  DATA_W  head payload (registered).
- out_ready_i  input  1  downstream consumes head.
- stall_i  input  1  hazard hold: freeze the stage.
- flush_i  input  1  kill all entries, insert a bubble.
- clr_cnt_i  input  1  synchronous clear of both counters.
- occ_o  output  2  entries held: 0, 1 or 2.
- stall_cnt_o  output  CNT_W  cycles with stall applied.
- flush_cnt_o  output  CNT_W  flush cycles.

Behaviour:
- Reset (rst_n_i=0, asynchronous): state EMPTY, main=0, skid=0, `out_valid_o`=0, `out_data_o`=0, `in_ready_o`=1, `occ_o`=0, both counters 0.
- The reset value of `in_ready_o` is 1, but no transfer occurs while reset is asserted.
- Release is synchronous to the next rising edge.
- Qualifiers:
  - in_fire = in_valid_i & in_ready_o & ~stall_i & ~flush_i.
  - out_fire = out_valid_o & out_ready_i & ~stall_i & ~flush_i.
- Registered outputs: `out_data_o` = main; `out_valid_o` = (state != EMPTY); `in_ready_o` = (state != FULL2); `occ_o` follows state.
- State machine (EMPTY / FULL1 / FULL2), evaluated each rising edge:
  - EMPTY: in_fire -> FULL1, main <= in_data_i. Otherwise hold.
  - FULL1, in_fire & out_fire -> FULL1, main <= in_data_i (pass-through, 1 transfer/cycle).
  - FULL1, in_fire & ~out_fire -> FULL2, skid <= in_data_i.
  - FULL1, ~in_fire & out_fire -> EMPTY, main <= 0.
  - FULL1, neither -> hold.
  - FULL2: out_fire -> FULL1, main <= skid, skid <= 0. Otherwise hold. in_fire is impossible because in_ready_o=0.
- Latency: 1 cycle from in_fire to out_valid_o. Throughput: 1 per cycle while out_ready_i=1.
- Ordering: strict FIFO, main before skid.
- Priority: flush_i > stall_i > handshake.
- Flush:
  - Next state EMPTY; main and skid <= 0 (zero payload = NOP bubble).
  - The input offered in the flush cycle is discarded, not accepted.
  - in_ready_o=1 on the following cycle.
- Stall:
  - State, main and skid are frozen.
  - Outputs hold their values; no in_fire or out_fire occurs regardless of valid/ready.
- Bubble semantics: whenever out_valid_o=0, out_data_o is 0.
- Counters:
  - stall_cnt increments when stall_i & ~flush_i.
  - flush_cnt increments when flush_i.
  - Both saturate at 2^CNT_W-1; no wrap.
  - clr_cnt_i takes priority over increment: the counter is 0 next cycle and the event in that cycle is not counted.
- Back-pressure: out_ready_i=0 with in_valid_i=1 fills to FULL2. in_ready_o drops on the cycle after the second entry is accepted; no entry is ever lost.
- Mid-operation reset: immediately returns to reset values; held entries are discarded.

Test Plan:
- Stream A0..A4 with in_valid_i=1 and out_ready_i=1 -> out_valid_o rises 1 cycle after A0; out_data_o = A0..A4 on consecutive cycles; occ_o stays 1.
- Hold out_ready_i=0 and offer 0x11, 0x22, 0x33 -> 0x11 and 0x22 accepted; in_ready_o=0 with occ_o=2 and 0x33 held upstream; release out_ready_i -> outputs 0x11, 0x22, 0x33 in order.
- In FULL2, pulse flush_i for 1 cycle while in_valid_i=1 with 0x44 -> next cycle out_valid_o=0, out_data_o=0, occ_o=0, flush_cnt_o=1; 0x44 not accepted.
- In FULL1 holding 0x55, assert stall_i for 3 cycles with out_ready_i=1 and in_valid_i=1 -> out_data_o stays 0x55, no acceptance, stall_cnt_o=3; on deassert, normal flow resumes.
- CNT_W=2, assert stall_i for 6 cycles -> stall_cnt_o saturates at 3; then clr_cnt_i -> 0.
- Assert rst_n_i=0 asynchronously mid-stream in FULL2 -> outputs go to reset values without waiting for a clock edge; after release, the first accepted entry appears 1 cycle later.
